// File: rtl/uart_pkg.sv
// Shared UART constants: receiver/transmitter FSM encodings and 16x oversampling timing.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rx_sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, midpoint-sampled, LSB-first frames with a stop-bit check.
// state | meaning: IDLE wait for low | START confirm start at midpoint | DATA shift bits | STOP time stop bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err
);

    localparam logic [4:0] S_MID       = 5'(MID_TICK);
    localparam logic [4:0] S_BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

    logic       rx_sync;
    logic [1:0] state_q, state_d;
    logic [4:0] s_q, s_d;   // 5 bits so a 2-stop-bit count (SB_TICK=32) fits
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .rx_i      (rx),
        .rx_sync_o (rx_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        rx_done_tick = 1'b0;
        frame_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_sync) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        // The shifter is cleared on the first data bit, not at start detection,
                        // so the previous byte stays visible on dout through the start bit.
                        b_d = {rx_sync, (n_q == 3'd0) ? 7'd0 : b_q[7:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d      = ST_IDLE;
                        rx_done_tick = 1'b1;
                        frame_err    = !rx_sync;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dout = b_q;

endmodule
